alu_op_decoder: RTL
===================

# alu_op_decoder

Registered instruction decode stage (ID/EX boundary) for the RV32IM pipeline; the producing end of the ALU interface. Each cycle it decodes one 32-bit RV32IM instruction into a 5-bit ALU opcode, operand-source selects, a sign-extended immediate, register addresses and memory/branch/write-back controls, then registers them for the EX stage. Stall and flush inputs control the pipeline register, and illegal encodings are flagged.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous reset, active low
- INSTRUCTION  in  32  instruction from IF/ID
- PC_IN  in  32  PC of INSTRUCTION
- IF_VALID  in  1  INSTRUCTION is real (not a bubble)
- STALL  in  1  hold all outputs
- FLUSH  in  1  load a bubble; takes priority over STALL
- EX_VALID  out  1  registered slot holds a real instruction
- ALU_OPCODE  out  5  ADD=0 SUB=1 SLL=2 SRL=3 SRA=4 SLT=5 SLTU=6 AND=7 OR=8 XOR=9 MUL=10 MULH=11 MULHSU=12 MULHU=13 DIV=14 DIVU=15 REM=16 REMU=17 (same values as the definitions.v macros)
- OP1_SEL  out  2  0=rs1, 1=PC, 2=zero
- OP2_SEL  out  1  0=rs2, 1=IMM
- RS1_ADDR, RS2_ADDR, RD_ADDR  out  5 each  register addresses
- IMM  out  32  sign-extended immediate
- FUNCT3  out  3  instr[14:12], passed through for load/store width and branch condition
- REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP  out  1 each  controls
- ILLEGAL  out  1  undecodable instruction
- PC_OUT  out  32  registered PC_IN

## Operation
- Bubble: EX_VALID=0, ILLEGAL=0, every control 0, ALU_OPCODE=0, all selects, addresses, IMM, FUNCT3 and PC_OUT = 0.
- Unused register fields are forced to 0. RS2_ADDR=0 for I/U/J types, RS1_ADDR=0 for LUI/AUIPC/JAL, RD_ADDR=0 for store/branch. This prevents false forwarding.
- Decode by opcode (instr[6:0]):
  - 0110011 R-type: OP2=rs2, REG_WRITE_EN=1.
    - f7=0000000: f3 0..7 maps to ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
    - f7=0100000: f3=0 gives SUB, f3=5 gives SRA.
    - f7=0000001: f3 0..7 maps to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
    - Any other f7/f3 combination is illegal.
  - 0010011 I-ALU: OP2=IMM (I-imm), REG_WRITE_EN=1. f3 as R-type, no SUB.
    - SLLI requires imm[11:5]=0.
    - f3=5: imm[11:5]=0 gives SRL, 0100000 gives SRA; anything else is illegal.
  - 0000011 load: ADD rs1+I-imm, MEM_READ=1, REG_WRITE_EN=1. f3 must be in {0,1,2,4,5}.
  - 0100011 store: ADD rs1+S-imm, MEM_WRITE=1. f3 must be in {0,1,2}.
  - 1100011 branch: ADD with OP1=PC, OP2=B-imm (target), BRANCH=1. f3=2 or 3 is illegal.
  - 1101111 JAL: ADD PC+J-imm, JUMP=1, REG_WRITE_EN=1.
  - 1100111 JALR: f3 must be 0. ADD rs1+I-imm, JUMP=1, REG_WRITE_EN=1.
  - 0110111 LUI: ADD with OP1=zero, OP2=U-imm, REG_WRITE_EN=1.
  - 0010111 AUIPC: ADD PC+U-imm, REG_WRITE_EN=1.
  - Any other opcode is illegal.
- Immediates: I=sext(i[31:20]); S=sext(i[31:25],i[11:7]); B=sext(i[31],i[7],i[30:25],i[11:8],0); J=sext(i[31],i[19:12],i[20],i[30:21],0); U={i[31:12],12'b0}.
- Illegal instruction: registered as bubble controls plus EX_VALID=1 and ILLEGAL=1. No write or memory enable is ever asserted for it.
- IF_VALID=0: a bubble is captured regardless of INSTRUCTION contents.

## Timing
- RESET_N low: all outputs are immediately the bubble (asynchronous). The first capture happens at the first rising edge after release.
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Priority at each edge: RESET_N, then FLUSH (bubble), then STALL (hold every output bit), then normal capture.
- FLUSH and STALL together: bubble loaded.
- STALL held across many cycles: outputs are bit-stable. INSTRUCTION changes during STALL are ignored.
- Reset asserted mid-stall or mid-stream: outputs go to bubble; there is no state other than the output register.
- All decode logic is combinational in front of a single register bank; there are no multi-cycle paths.

## Test plan
- Reset low with random INSTRUCTION -> all outputs 0. Release, then 0x002081B3 with IF_VALID=1 -> next cycle: ALU_OPCODE=0, RS1=1, RS2=2, RD=3, OP2_SEL=0, REG_WRITE_EN=1, EX_VALID=1.
- M-extension and shift-immediate decode:
  - 0x027332B3 -> MULHU (13), RS1=6, RS2=7, RD=5.
  - 0x40325213 -> SRA (4), OP2_SEL=1, IMM=3, RS2_ADDR=0.
- Immediates:
  - 0xFFF00093 -> ADD, IMM=0xFFFFFFFF, RD=1.
  - 0x12345137 -> OP1_SEL=2, IMM=0x12345000.
  - 0x0020A423 (SW) -> IMM=8, MEM_WRITE=1, REG_WRITE_EN=0, RD_ADDR=0, FUNCT3=2.
- Illegal encodings: 0x00000000 and R-type with f7=0100000, f3=1 -> ILLEGAL=1, EX_VALID=1, all enables 0.
- Stall/flush sequence:
  - Capture ADD, then STALL=1 for 3 cycles while INSTRUCTION changes -> outputs unchanged.
  - STALL=1 with FLUSH=1 -> bubble.
  - IF_VALID=0 -> bubble.
- Async reset pulse between clock edges during a valid instruction -> outputs drop to 0 before the next edge.

Source files
------------

// File: rtl/alu_op_decoder.sv
// Purpose : RV32IM decode stage; turns one instruction into registered ALU/memory/branch controls for EX.
// Latency : 1 cycle (decode is combinational, a single register bank sits at the ID/EX boundary).
// Backpr. : STALL holds every output bit; FLUSH (wins over STALL) loads a bubble; no internal buffering.
//
// Ports:
//   CLK, RESET_N               rising-edge clock, async active-low reset (outputs -> bubble)
//   INSTRUCTION, PC_IN         instruction and its PC from IF/ID
//   IF_VALID                   instruction is real; 0 captures a bubble
//   STALL, FLUSH               pipeline register hold / bubble load
//   EX_VALID .. PC_OUT         registered decode results (see field list below)
module alu_op_decoder (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] PC_IN,
    input  logic        IF_VALID,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic        EX_VALID,
    output logic [4:0]  ALU_OPCODE,
    output logic [1:0]  OP1_SEL,
    output logic        OP2_SEL,
    output logic [4:0]  RS1_ADDR,
    output logic [4:0]  RS2_ADDR,
    output logic [4:0]  RD_ADDR,
    output logic [31:0] IMM,
    output logic [2:0]  FUNCT3,
    output logic        REG_WRITE_EN,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        BRANCH,
    output logic        JUMP,
    output logic        ILLEGAL,
    output logic [31:0] PC_OUT
);

    typedef struct packed {
        logic        ex_valid;
        logic [4:0]  alu_opcode;
        logic [1:0]  op1_sel;
        logic        op2_sel;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic        reg_write_en;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [31:0] pc;
    } ex_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SRL  = 5'd3;
    localparam logic [4:0] ALU_SRA  = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLTU = 5'd6;
    localparam logic [4:0] ALU_AND  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_XOR  = 5'd9;
    localparam logic [4:0] ALU_MUL  = 5'd10;

    localparam logic [1:0] OP1_RS1  = 2'd0;
    localparam logic [1:0] OP1_PC   = 2'd1;
    localparam logic [1:0] OP1_ZERO = 2'd2;

    // Base-ISA funct3 -> ALU op (shared by R-type f7=0 and I-ALU).
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0:    base_op = ALU_ADD;
            3'd1:    base_op = ALU_SLL;
            3'd2:    base_op = ALU_SLT;
            3'd3:    base_op = ALU_SLTU;
            3'd4:    base_op = ALU_XOR;
            3'd5:    base_op = ALU_SRL;
            3'd6:    base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
    logic        legal;
    ex_t         dec_dat;
    ex_t         nxt_dat;
    ex_t         ex_q;

    assign opc    = INSTRUCTION[6:0];
    assign f3     = INSTRUCTION[14:12];
    assign f7     = INSTRUCTION[31:25];
    assign imm_i  = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
    assign imm_s  = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
    assign imm_b  = {{20{INSTRUCTION[31]}}, INSTRUCTION[7], INSTRUCTION[30:25],
                     INSTRUCTION[11:8], 1'b0};
    assign imm_j  = {{12{INSTRUCTION[31]}}, INSTRUCTION[19:12], INSTRUCTION[20],
                     INSTRUCTION[30:21], 1'b0};
    assign imm_u  = {INSTRUCTION[31:12], 12'b0};
    // Shift-immediates carry only the shamt; the funct7 bits are opcode, not operand.
    assign imm_sh = {27'b0, INSTRUCTION[24:20]};

    always_comb begin
        dec_dat          = '0;
        legal            = 1'b1;
        dec_dat.ex_valid = 1'b1;
        dec_dat.funct3   = f3;
        dec_dat.pc       = PC_IN;
        // Unused register fields stay 0 so forwarding never matches on them.
        case (opc)
            OPC_OP: begin
                dec_dat.rs1_addr     = INSTRUCTION[19:15];
                dec_dat.rs2_addr     = INSTRUCTION[24:20];
                dec_dat.rd_addr      = INSTRUCTION[11:7];
                dec_dat.reg_write_en = 1'b1;
                case (f7)
                    7'b0000000: dec_dat.alu_opcode = base_op(f3);
                    7'b0100000: begin
                        if (f3 == 3'd0)      dec_dat.alu_opcode = ALU_SUB;
                        else if (f3 == 3'd5) dec_dat.alu_opcode = ALU_SRA;
                        else                 legal = 1'b0;
                    end
                    // MUL..REMU are contiguous in funct3 order.
                    7'b0000001: dec_dat.alu_opcode = ALU_MUL + {2'b00, f3};
                    default:    legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec_dat.rs1_addr     = INSTRUCTION[19:15];
                dec_dat.rd_addr      = INSTRUCTION[11:7];
                dec_dat.op2_sel      = 1'b1;
                dec_dat.reg_write_en = 1'b1;
                dec_dat.imm          = imm_i;
                dec_dat.alu_opcode   = base_op(f3);
                if (f3 == 3'd1) begin
                    dec_dat.imm = imm_sh;
                    if (f7 != 7'b0000000) legal = 1'b0;
                end else if (f3 == 3'd5) begin
                    dec_dat.imm = imm_sh;
                    if (f7 == 7'b0100000)      dec_dat.alu_opcode = ALU_SRA;
                    else if (f7 != 7'b0000000) legal = 1'b0;
                end
            end
            OPC_LOAD: begin
                dec_dat.rs1_addr     = INSTRUCTION[19:15];
                dec_dat.rd_addr      = INSTRUCTION[11:7];
                dec_dat.op2_sel      = 1'b1;
                dec_dat.imm          = imm_i;
                dec_dat.mem_read     = 1'b1;
                dec_dat.reg_write_en = 1'b1;
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) legal = 1'b0;
            end
            OPC_STORE: begin
                dec_dat.rs1_addr  = INSTRUCTION[19:15];
                dec_dat.rs2_addr  = INSTRUCTION[24:20];
                dec_dat.op2_sel   = 1'b1;
                dec_dat.imm       = imm_s;
                dec_dat.mem_write = 1'b1;
                if (f3 > 3'd2) legal = 1'b0;
            end
            OPC_BRANCH: begin
                // ALU computes the target; the comparison uses rs1/rs2 elsewhere.
                dec_dat.rs1_addr = INSTRUCTION[19:15];
                dec_dat.rs2_addr = INSTRUCTION[24:20];
                dec_dat.op1_sel  = OP1_PC;
                dec_dat.op2_sel  = 1'b1;
                dec_dat.imm      = imm_b;
                dec_dat.branch   = 1'b1;
                if (f3 == 3'd2 || f3 == 3'd3) legal = 1'b0;
            end
            OPC_JAL: begin
                dec_dat.rd_addr      = INSTRUCTION[11:7];
                dec_dat.op1_sel      = OP1_PC;
                dec_dat.op2_sel      = 1'b1;
                dec_dat.imm          = imm_j;
                dec_dat.jump         = 1'b1;
                dec_dat.reg_write_en = 1'b1;
            end
            OPC_JALR: begin
                dec_dat.rs1_addr     = INSTRUCTION[19:15];
                dec_dat.rd_addr      = INSTRUCTION[11:7];
                dec_dat.op2_sel      = 1'b1;
                dec_dat.imm          = imm_i;
                dec_dat.jump         = 1'b1;
                dec_dat.reg_write_en = 1'b1;
                if (f3 != 3'd0) legal = 1'b0;
            end
            OPC_LUI: begin
                dec_dat.rd_addr      = INSTRUCTION[11:7];
                dec_dat.op1_sel      = OP1_ZERO;
                dec_dat.op2_sel      = 1'b1;
                dec_dat.imm          = imm_u;
                dec_dat.reg_write_en = 1'b1;
            end
            OPC_AUIPC: begin
                dec_dat.rd_addr      = INSTRUCTION[11:7];
                dec_dat.op1_sel      = OP1_PC;
                dec_dat.op2_sel      = 1'b1;
                dec_dat.imm          = imm_u;
                dec_dat.reg_write_en = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal instructions travel as a flagged bubble so no enable can leak out.
    always_comb begin
        nxt_dat = '0;
        if (IF_VALID) begin
            if (legal) begin
                nxt_dat = dec_dat;
            end else begin
                nxt_dat.ex_valid = 1'b1;
                nxt_dat.illegal  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ex_q <= '0;
        end else if (FLUSH) begin
            ex_q <= '0;
        end else if (!STALL) begin
            ex_q <= nxt_dat;
        end
    end

    assign EX_VALID     = ex_q.ex_valid;
    assign ALU_OPCODE   = ex_q.alu_opcode;
    assign OP1_SEL      = ex_q.op1_sel;
    assign OP2_SEL      = ex_q.op2_sel;
    assign RS1_ADDR     = ex_q.rs1_addr;
    assign RS2_ADDR     = ex_q.rs2_addr;
    assign RD_ADDR      = ex_q.rd_addr;
    assign IMM          = ex_q.imm;
    assign FUNCT3       = ex_q.funct3;
    assign REG_WRITE_EN = ex_q.reg_write_en;
    assign MEM_READ     = ex_q.mem_read;
    assign MEM_WRITE    = ex_q.mem_write;
    assign BRANCH       = ex_q.branch;
    assign JUMP         = ex_q.jump;
    assign ILLEGAL      = ex_q.illegal;
    assign PC_OUT       = ex_q.pc;

endmodule
